// File: rtl/dot_pkg.sv
// dot_pkg: width rules and narrowing helpers shared by dot_product_pipe.
// sat_narrow is used only by the DOT_SAT_EN build.
package dot_pkg;

   // Generous enough for 2*WIDTH+LOG2_LANES with WIDTH up to 60, LANES up to 256.
   localparam int ACC_MAX_W = 128;

   typedef logic signed [ACC_MAX_W-1:0] acc_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int acc_width(input int w, input int lanes);
      return 2 * w + clog2(lanes);
   endfunction

   function automatic acc_t sat_narrow(input acc_t v, input int w);
      acc_t hi;
      acc_t lo;
      hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
      lo = -hi - acc_t'(1);
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/dot_tree_level.sv
// dot_tree_level: one registered adder-tree level, N inputs to N/2 sums.
// Each sum is one bit wider than its inputs so the tree cannot overflow.
module dot_tree_level
   import dot_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 64
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  en_in,
   input  logic                  valid_in,
   input  logic [N-1:0][IW-1:0]  d_in,
   output logic                  valid_out,
   output logic [N/2-1:0][IW:0]  sum_out
);

   logic [N/2-1:0][IW:0] sum_d;
   logic [N/2-1:0][IW:0] sum_q;
   logic                 valid_d;
   logic                 valid_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N / 2; i++) begin
         sum_d[i] = (IW+1)'(signed'(d_in[2*i]))
                  + (IW+1)'(signed'(d_in[2*i+1]));
      end
      valid_d = valid_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= 1'b0;
      end else if (en_in) begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (en_in) begin
         sum_q <= sum_d;
      end
   end

   assign valid_out = valid_q;
   assign sum_out   = sum_q;

endmodule

// File: rtl/dot_product_pipe.sv
// dot_product_pipe: N-lane signed dot product, multiplier bank + adder tree.
// Define DOT_SAT_EN for a saturating final stage with a sat_out flag.
module dot_product_pipe
   import dot_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int LANES       = 4,
   parameter int FIXED_POINT = 0,
   parameter int FRAC_BITS   = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [LANES-1:0][WIDTH-1:0]   x_in,
   input  logic [LANES-1:0][WIDTH-1:0]   y_in,
   input  logic                          valid_in,
   output logic                          ready_in,
   output logic signed [WIDTH-1:0]       out,
   output logic                          valid_out,
`ifdef DOT_SAT_EN
   output logic                          sat_out,
`endif
   input  logic                          ready_out
);

   localparam int LOG2_LANES = clog2(LANES);
   localparam int PW         = 2 * WIDTH;
   localparam int ACC_W      = acc_width(WIDTH, LANES);
   localparam int SHIFT      = (FIXED_POINT != 0) ? FRAC_BITS : 0;

   logic                        adv;
   logic [LANES-1:0][PW-1:0]    prod_d;
   logic [LANES-1:0][PW-1:0]    prod_q;
   logic                        v0_d;
   logic                        v0_q;
   logic signed [ACC_W-1:0]     tree_sum;
   logic                        tree_v;
   logic [WIDTH-1:0]            out_d;
   logic [WIDTH-1:0]            out_q;
   logic                        valid_out_q;

   // One global enable: a stalled output freezes every stage.
   assign adv      = !valid_out_q | ready_out;
   assign ready_in = adv;

   always_comb begin
      prod_d = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = PW'(signed'(x_in[i])) * PW'(signed'(y_in[i]));
      end
      v0_d = valid_in;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         v0_q <= 1'b0;
      end else if (adv) begin
         v0_q <= v0_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (adv) begin
         prod_q <= prod_d;
      end
   end

   for (genvar l = 0; l < LOG2_LANES; l++) begin : g_lvl
      localparam int N  = LANES >> l;
      localparam int IW = PW + l;

      logic [N-1:0][IW-1:0]  d;
      logic                  v;
      logic [N/2-1:0][IW:0]  sum;
      logic                  sv;

      if (l == 0) begin : g_src
         assign d = prod_q;
         assign v = v0_q;
      end else begin : g_src
         assign d = g_lvl[l-1].sum;
         assign v = g_lvl[l-1].sv;
      end

      dot_tree_level #(
         .N  (N),
         .IW (IW)
      ) u_lvl (
         .clk_in    (clk_in),
         .rst_in    (rst_in),
         .en_in     (adv),
         .valid_in  (v),
         .d_in      (d),
         .valid_out (sv),
         .sum_out   (sum)
      );
   end

   assign tree_sum = g_lvl[LOG2_LANES-1].sum;
   assign tree_v   = g_lvl[LOG2_LANES-1].sv;

`ifdef DOT_SAT_EN
   acc_t scaled;
   acc_t clamped;
   logic sat_d;
   logic sat_q;

   always_comb begin
      scaled  = acc_t'(tree_sum) >>> SHIFT;
      clamped = sat_narrow(scaled, WIDTH);
      sat_d   = (clamped != scaled);
      out_d   = clamped[WIDTH-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sat_q <= 1'b0;
      end else if (adv && tree_v) begin
         sat_q <= sat_d;
      end
   end

   assign sat_out = sat_q;
`else
   always_comb begin
      out_d = WIDTH'(acc_t'(tree_sum) >>> SHIFT);
   end
`endif

   // Bubbles leave out untouched so it stays 0 after reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_out_q <= 1'b0;
         out_q       <= '0;
      end else if (adv) begin
         valid_out_q <= tree_v;
         if (tree_v) begin
            out_q <= out_d;
         end
      end
   end

   assign out       = out_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_dot_product_pipe.sv
// tb_dot_product_pipe: directed and random checks of dot_product_pipe.
// Four instances cover integer/fixed-point and LANES of 4, 8 and 2.
module tb_dot_product_pipe;

   localparam int W = 32;
`ifdef DOT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   errs = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   logic [3:0][W-1:0] a_x, a_y;
   logic              a_vi, a_ri, a_vo, a_ro;
   logic [W-1:0]      a_out;
   logic              a_sat;

   logic [3:0][W-1:0] f_x, f_y;
   logic              f_vi, f_ri, f_vo, f_ro;
   logic [W-1:0]      f_out;
   logic              f_sat;

   logic [7:0][W-1:0] r_x, r_y;
   logic              r_vi, r_ro, sel;
   logic              r_ri, r_vo, r_sat;
   logic [W-1:0]      r_out;
   logic              e_ri, e_vo, e_sat, t_ri, t_vo, t_sat;
   logic [W-1:0]      e_out, t_out;

   assign r_ri  = sel ? t_ri  : e_ri;
   assign r_vo  = sel ? t_vo  : e_vo;
   assign r_out = sel ? t_out : e_out;
   assign r_sat = sel ? t_sat : e_sat;

`ifndef DOT_SAT_EN
   assign a_sat = 1'b0;
   assign f_sat = 1'b0;
   assign e_sat = 1'b0;
   assign t_sat = 1'b0;
`endif

   dot_product_pipe #(.WIDTH(W), .LANES(4)) u_a (
      .clk_in(clk), .rst_in(rst), .x_in(a_x), .y_in(a_y),
      .valid_in(a_vi), .ready_in(a_ri), .out(a_out),
      .valid_out(a_vo),
`ifdef DOT_SAT_EN
      .sat_out(a_sat),
`endif
      .ready_out(a_ro));

   dot_product_pipe #(.WIDTH(W), .LANES(4), .FIXED_POINT(1),
                      .FRAC_BITS(16)) u_f (
      .clk_in(clk), .rst_in(rst), .x_in(f_x), .y_in(f_y),
      .valid_in(f_vi), .ready_in(f_ri), .out(f_out),
      .valid_out(f_vo),
`ifdef DOT_SAT_EN
      .sat_out(f_sat),
`endif
      .ready_out(f_ro));

   dot_product_pipe #(.WIDTH(W), .LANES(8)) u_e (
      .clk_in(clk), .rst_in(rst), .x_in(r_x), .y_in(r_y),
      .valid_in(r_vi & !sel), .ready_in(e_ri), .out(e_out),
      .valid_out(e_vo),
`ifdef DOT_SAT_EN
      .sat_out(e_sat),
`endif
      .ready_out(r_ro | sel));

   dot_product_pipe #(.WIDTH(W), .LANES(2)) u_t (
      .clk_in(clk), .rst_in(rst), .x_in(r_x[1:0]), .y_in(r_y[1:0]),
      .valid_in(r_vi & sel), .ready_in(t_ri), .out(t_out),
      .valid_out(t_vo),
`ifdef DOT_SAT_EN
      .sat_out(t_sat),
`endif
      .ready_out(r_ro | !sel));

   // Exact integer math, floor division for the fixed-point rescale.
   function automatic logic [32:0] ref_dot(input int lanes, input bit fp,
                                          input logic [255:0] xv,
                                          input logic [255:0] yv);
      logic signed [127:0] s, a, b, q, p, hi, lo;
      logic sat;
      s = '0;
      sat = 1'b0;
      for (int i = 0; i < lanes; i++) begin
         a = $signed(xv[i*32 +: 32]);
         b = $signed(yv[i*32 +: 32]);
         s = s + a * b;
      end
      if (fp) begin
         p = 128'sd65536;
         q = s / p;
         if (s < 0 && q * p != s) q = q - 1;
         s = q;
      end
      hi = 128'sd2147483647;
      lo = -hi - 1;
      if (SAT && s > hi) begin
         s = hi;
         sat = 1'b1;
      end else if (SAT && s < lo) begin
         s = lo;
         sat = 1'b1;
      end
      return {sat, s[31:0]};
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 7))
         0: return 32'h7fffffff;
         1: return 32'h80000000;
         2: return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (a_vo !== 1'b0) begin
         errs++;
         $display("FAIL reset_valid: got %b want 0", a_vo);
      end
      checks++;
      if (a_out !== '0) begin
         errs++;
         $display("FAIL reset_out: got %h want 0", a_out);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (a_ri !== 1'b1 || e_vo !== 1'b0 || t_vo !== 1'b0) begin
         errs++;
         $display("FAIL reset_ready: got ri=%b e_vo=%b t_vo=%b want 1,0,0",
                  a_ri, e_vo, t_vo);
      end
   endtask

   task automatic test_latency();
      int lat;
      @(negedge clk);
      a_x = {32'd4, 32'd3, 32'd2, 32'd1};
      a_y = {32'd8, 32'd7, 32'd6, 32'd5};
      a_vi = 1'b1;
      a_ro = 1'b1;
      #1;
      checks++;
      if (a_ri !== 1'b1) begin
         errs++;
         $display("FAIL lat_ready: got %b want 1", a_ri);
      end
      @(negedge clk);
      a_vi = 1'b0;
      lat = 1;
      while (!a_vo && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 4) begin
         errs++;
         $display("FAIL lat_cycles: got %0d want 4", lat);
      end
      checks++;
      if (a_out !== 32'd70) begin
         errs++;
         $display("FAIL lat_value: got %0d want 70", a_out);
      end
      @(negedge clk);
   endtask

   task automatic test_fixed();
      logic [31:0] got[$];
      @(negedge clk);
      f_ro = 1'b1;
      f_vi = 1'b1;
      f_x = {32'd0, 32'd0, 32'hffff8000, 32'h00010000};
      f_y = {32'd0, 32'd0, 32'h00020000, 32'h00020000};
      @(negedge clk);
      f_x = {32'd0, 32'd0, 32'd0, 32'hffffffff};
      f_y = {32'd0, 32'd0, 32'd0, 32'h00008000};
      @(negedge clk);
      f_vi = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (f_vo) got.push_back(f_out);
         @(negedge clk);
      end
      checks++;
      if (got.size() != 2) begin
         errs++;
         $display("FAIL fix_count: got %0d want 2", got.size());
      end else begin
         checks++;
         if (got[0] !== 32'h00010000) begin
            errs++;
            $display("FAIL fix_one: got %h want 00010000", got[0]);
         end
         checks++;
         if (got[1] !== 32'hffffffff) begin
            errs++;
            $display("FAIL fix_floor: got %h want ffffffff", got[1]);
         end
      end
   endtask

   task automatic test_stall();
      logic [32:0] q[$];
      logic [32:0] ex;
      logic [31:0] held;
      bit          in_stall;
      int          sent, got;
      in_stall = 1'b0;
      sent = 0;
      got = 0;
      held = '0;
      for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
         @(negedge clk);
         a_ro = !(cyc >= 6 && cyc < 11);
         a_vi = (sent < 8);
         for (int i = 0; i < 4; i++) begin
            a_x[i] = rnd_word();
            a_y[i] = rnd_word();
         end
         #1;
         if (a_vo && !a_ro) begin
            checks++;
            if (a_ri !== 1'b0) begin
               errs++;
               $display("FAIL stall_ready: got %b want 0", a_ri);
            end
            if (in_stall) begin
               checks++;
               if (a_out !== held) begin
                  errs++;
                  $display("FAIL stall_hold: got %h want %h", a_out, held);
               end
            end
            held = a_out;
            in_stall = 1'b1;
         end else begin
            in_stall = 1'b0;
         end
         if (a_vo && a_ro) begin
            checks++;
            got++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL stall_extra: got %h want no output", a_out);
            end else begin
               ex = q.pop_front();
               if (a_out !== ex[31:0] || (SAT && a_sat !== ex[32])) begin
                  errs++;
                  $display("FAIL stall_data: got %h/%b want %h/%b",
                           a_out, a_sat, ex[31:0], ex[32]);
               end
            end
         end
         if (a_vi && a_ri) begin
            q.push_back(ref_dot(4, 1'b0, 256'(a_x), 256'(a_y)));
            sent++;
         end
      end
      checks++;
      if (got != 8 || q.size() != 0) begin
         errs++;
         $display("FAIL stall_count: got %0d left %0d want 8 left 0",
                  got, q.size());
      end
      @(negedge clk);
      a_vi = 1'b0;
      a_ro = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_overflow();
      int n;
      @(negedge clk);
      a_ro = 1'b1;
      a_vi = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_x[i] = 32'h7fffffff;
         a_y[i] = 32'h7fffffff;
      end
      @(negedge clk);
      a_vi = 1'b0;
      n = 0;
      while (!a_vo && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (a_vo !== 1'b1) begin
         errs++;
         $display("FAIL ovf_timeout: got valid=%b want 1", a_vo);
      end
      checks++;
      if (a_out !== (SAT ? 32'h7fffffff : 32'h00000004)) begin
         errs++;
         $display("FAIL ovf_value: got %h want %h", a_out,
                  SAT ? 32'h7fffffff : 32'h00000004);
      end
      if (SAT) begin
         checks++;
         if (a_sat !== 1'b1) begin
            errs++;
            $display("FAIL ovf_sat: got %b want 1", a_sat);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_flight();
      a_ro = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a_vi = 1'b1;
         a_x = {$urandom, $urandom, $urandom, $urandom};
         a_y = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      a_vi = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (a_ri !== 1'b1) begin
         errs++;
         $display("FAIL rstfl_ready: got %b want 1", a_ri);
      end
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         checks++;
         if (a_vo !== 1'b0 || a_out !== '0) begin
            errs++;
            $display("FAIL rstfl_idle: got valid=%b out=%h want 0,0",
                     a_vo, a_out);
         end
      end
   endtask

   task automatic test_random(input bit s, input int lanes, input int nvec);
      logic [32:0] q[$];
      logic [32:0] ex;
      int          sent, got, cyc;
      sent = 0;
      got = 0;
      cyc = 0;
      sel = s;
      while (got < nvec && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         r_ro = 1'($urandom_range(0, 1));
         r_vi = (sent < nvec) ? 1'($urandom_range(0, 1)) : 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_x[i] = rnd_word();
            r_y[i] = rnd_word();
         end
         #1;
         if (r_vo && r_ro) begin
            checks++;
            got++;
            if (q.size() == 0) begin
               errs++;
               $display("FAIL rand%0d_extra: got %h want no output",
                        lanes, r_out);
            end else begin
               ex = q.pop_front();
               if (r_out !== ex[31:0] || (SAT && r_sat !== ex[32])) begin
                  errs++;
                  $display("FAIL rand%0d_data: got %h/%b want %h/%b",
                           lanes, r_out, r_sat, ex[31:0], ex[32]);
               end
            end
         end
         if (r_vi && r_ri) begin
            q.push_back(ref_dot(lanes, 1'b0, r_x, r_y));
            sent++;
         end
      end
      checks++;
      if (got != nvec || q.size() != 0) begin
         errs++;
         $display("FAIL rand%0d_count: got %0d left %0d want %0d left 0",
                  lanes, got, q.size(), nvec);
      end
      @(negedge clk);
      r_vi = 1'b0;
      r_ro = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      a_vi = 1'b0; a_ro = 1'b0; a_x = '0; a_y = '0;
      f_vi = 1'b0; f_ro = 1'b1; f_x = '0; f_y = '0;
      r_vi = 1'b0; r_ro = 1'b1; r_x = '0; r_y = '0;
      sel = 1'b0;
      test_reset();
      test_latency();
      test_fixed();
      test_stall();
      test_overflow();
      test_reset_flight();
      test_random(1'b0, 8, 6000);
      test_random(1'b1, 2, 6000);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
